// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl: refresh scheduler sitting directly above the HD44780-style
// `lcd` driver. Holds a 32-cell frame buffer (row 0 = cells 0-15, row 1 =
// cells 16-31) and, whenever it is dirty, replays it to the panel as
// {DDRAM 0x00 cmd, 16 chars, DDRAM 0x40 cmd, 16 chars} over the driver's
// d_in / data_ready / busy_flag handshake.
// Optional feature macro: LCD_CURSOR_EN -- appends a cursor-positioning
// command as a final item and refreshes when cursor_pos changes while idle.
module lcd_frame_ctrl #(
    parameter int CLK_FREQ    = 50000000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       internal_reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clear_req,
    input  logic [4:0] cursor_pos,
    input  logic       lcd_busy,
    output logic [8:0] lcd_d_in,
    output logic       lcd_data_ready,
    output logic       refreshing,
    output logic       frame_done
);

    localparam int TO_W = $clog2(ACK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [7:0] BLANK = 8'h20;
`ifdef LCD_CURSOR_EN
    localparam logic [5:0] LAST_IDX = 6'd34;
`else
    localparam logic [5:0] LAST_IDX = 6'd33;
`endif

    typedef enum logic [2:0] {
        WAIT_INIT_HI = 3'd0,
        WAIT_INIT_LO = 3'd1,
        IDLE         = 3'd2,
        LOAD         = 3'd3,
        ISSUE        = 3'd4,
        WAIT_ACK     = 3'd5,
        WAIT_DONE    = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [7:0]      frame_buf_r [32];
    logic            dirty_r;
    logic [5:0]      idx_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            start_s;
    logic            load_s;
    logic            strobe_s;
    logic            advance_s;
    logic            finish_s;
    logic            cursor_chg_s;
    logic [4:0]      char_addr_s;
    logic [8:0]      item_s;

    // CLK_FREQ is informational only; keep it referenced.
    logic [31:0] unused_clk_freq_s;
    assign unused_clk_freq_s = 32'(CLK_FREQ);

`ifdef LCD_CURSOR_EN
    logic [4:0] cursor_prev_r;

    // Track the last cursor position so a move while idle triggers a refresh.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            cursor_prev_r <= cursor_pos;
        end else begin
            cursor_prev_r <= cursor_pos;
        end
    end

    assign cursor_chg_s = (state_r == IDLE) && (cursor_pos != cursor_prev_r);
`else
    logic [4:0] unused_cursor_s;
    assign unused_cursor_s = cursor_pos;
    assign cursor_chg_s    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            state_r <= WAIT_INIT_HI;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and one-cycle action decodes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        load_s      = 1'b0;
        strobe_s    = 1'b0;
        advance_s   = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            WAIT_INIT_HI: begin
                // The driver raises busy on its first initialisation cycle.
                if (lcd_busy) begin
                    state_nxt_s = WAIT_INIT_LO;
                end else begin
                    state_nxt_s = WAIT_INIT_HI;
                end
            end
            WAIT_INIT_LO: begin
                if (!lcd_busy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_INIT_LO;
                end
            end
            IDLE: begin
                if (dirty_r) begin
                    start_s     = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                load_s      = 1'b1;
                state_nxt_s = ISSUE;
            end
            ISSUE: begin
                if (!lcd_busy) begin
                    strobe_s    = 1'b1;
                    state_nxt_s = WAIT_ACK;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT_ACK: begin
                if (lcd_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (to_cnt_r == TO_LAST) begin
                    // Driver never acknowledged: re-issue the same item.
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!lcd_busy) begin
                    if (idx_r == LAST_IDX) begin
                        finish_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        advance_s   = 1'b1;
                        state_nxt_s = LOAD;
                    end
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = WAIT_INIT_HI;
            end
        endcase
    end

    // Map the item index to the word sent to the driver, reading the buffer live.
    always_comb begin
        if (idx_r <= 6'd16) begin
            char_addr_s = 5'(idx_r - 6'd1);
        end else begin
            char_addr_s = 5'(idx_r - 6'd2);
        end
        if (idx_r == 6'd0) begin
            item_s = 9'h080;
        end else if (idx_r <= 6'd16) begin
            item_s = {1'b1, frame_buf_r[char_addr_s]};
        end else if (idx_r == 6'd17) begin
            item_s = 9'h0C0;
        end else if (idx_r <= 6'd33) begin
            item_s = {1'b1, frame_buf_r[char_addr_s]};
        end else begin
`ifdef LCD_CURSOR_EN
            item_s = {1'b0, 1'b1, cursor_pos[4], 2'b00, cursor_pos[3:0]};
`else
            item_s = 9'h0C0;
`endif
        end
    end

    // Frame buffer: clear first, then a same-cycle write still lands.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            for (int i = 0; i < 32; i++) begin
                frame_buf_r[i] <= BLANK;
            end
        end else begin
            if (clear_req) begin
                for (int i = 0; i < 32; i++) begin
                    frame_buf_r[i] <= BLANK;
                end
            end
            if (wr_en) begin
                frame_buf_r[wr_addr] <= wr_data;
            end
        end
    end

    // Dirty flag: consumed at frame start, re-set by any buffer/cursor change.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            dirty_r <= 1'b1;
        end else begin
            if (start_s) begin
                dirty_r <= 1'b0;
            end
            if (wr_en || clear_req || cursor_chg_s) begin
                dirty_r <= 1'b1;
            end
        end
    end

    // Item index and acknowledge-timeout counter.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            idx_r    <= 6'd0;
            to_cnt_r <= '0;
        end else begin
            if (start_s) begin
                idx_r <= 6'd0;
            end else if (advance_s) begin
                idx_r <= idx_r + 6'd1;
            end
            if (strobe_s) begin
                to_cnt_r <= '0;
            end else if (state_r == WAIT_ACK) begin
                to_cnt_r <= to_cnt_r + 1'b1;
            end
        end
    end

    // Registered outputs; d_in only changes in LOAD so it is held through WAIT_DONE.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            lcd_d_in       <= 9'h000;
            lcd_data_ready <= 1'b0;
            refreshing     <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            lcd_data_ready <= strobe_s;
            frame_done     <= finish_s;
            if (load_s) begin
                lcd_d_in <= item_s;
            end
            if (start_s) begin
                refreshing <= 1'b1;
            end else if (finish_s) begin
                refreshing <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Self-checking bench for lcd_frame_ctrl: an LCD driver stub answers strobes,
// a monitor logs every strobed word, and a frame-buffer reference model
// produces the expected 34 (or 35 with LCD_CURSOR_EN) words per frame.
`timescale 1ns/1ps
module tb_lcd_frame_ctrl;

    localparam int ACK_TIMEOUT = 16;
`ifdef LCD_CURSOR_EN
    localparam int NITEMS = 35;
`else
    localparam int NITEMS = 34;
`endif
    localparam logic [4:0] CURSOR = 5'd18;

    logic       clock = 1'b0;
    logic       internal_reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       clear_req;
    logic [4:0] cursor_pos;
    logic       lcd_busy;
    logic [8:0] lcd_d_in;
    logic       lcd_data_ready;
    logic       refreshing;
    logic       frame_done;

    logic init_busy = 1'b0;
    logic stub_busy;
    logic ignore_req = 1'b0;
    assign lcd_busy = init_busy | stub_busy;

    always #5 clock = ~clock;

    lcd_frame_ctrl #(.CLK_FREQ(50000000), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clock(clock), .internal_reset(internal_reset), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
        .cursor_pos(cursor_pos), .lcd_busy(lcd_busy), .lcd_d_in(lcd_d_in),
        .lcd_data_ready(lcd_data_ready), .refreshing(refreshing),
        .frame_done(frame_done)
    );

    // ---------------- driver stub: busy rises 2 cycles after a strobe ----
    int   rise_in;
    int   hold;
    int   dur_next;
    logic ignored;
    always @(posedge clock) begin
        if (internal_reset) begin
            stub_busy <= 1'b0; rise_in <= 0; hold <= 0; ignored <= 1'b0; dur_next <= 2;
        end else begin
            if (rise_in == 1) begin
                stub_busy <= 1'b1; hold <= dur_next; rise_in <= 0;
            end else if (hold > 1) begin
                hold <= hold - 1;
            end else if (hold == 1) begin
                stub_busy <= 1'b0; hold <= 0;
            end
            if (lcd_data_ready) begin
                if (ignore_req && !ignored) begin
                    ignored <= 1'b1;
                end else begin
                    rise_in  <= 1;
                    dur_next <= lcd_d_in[8] ? int'($urandom_range(2, 5)) : int'($urandom_range(6, 10));
                end
            end
            if (!ignore_req) ignored <= 1'b0;
        end
    end

    // ---------------- monitor --------------------------------------------
    int         cyc = 0;
    logic [8:0] sq[$];
    int         scyc[$];
    int         done_cnt = 0;
    int         viol_pulse = 0;
    int         viol_done = 0;
    int         viol_hold = 0;
    logic       prev_rdy = 1'b0;
    logic       prev_ref = 1'b0;
    logic [8:0] last_word = 9'h000;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (lcd_data_ready) begin
            sq.push_back(lcd_d_in); scyc.push_back(cyc); last_word = lcd_d_in;
        end
        if (lcd_data_ready && prev_rdy) viol_pulse++;
        if (frame_done) begin
            done_cnt++;
            if (refreshing || !prev_ref) viol_done++;
        end
        if (stub_busy && !internal_reset && lcd_d_in !== last_word) viol_hold++;
        prev_rdy = lcd_data_ready;
        prev_ref = refreshing;
    end

    // ---------------- reference model ------------------------------------
    logic [7:0] mbuf [32];
    logic [8:0] exp_q[$];
    logic [8:0] saved_q[$];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       clr;
        logic [4:0] addr;
        logic [7:0] data;
        int         item;
        logic [8:0] exp_word;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_fill();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    endtask

    task automatic model_write(input logic clr, input logic we, input logic [4:0] a, input logic [7:0] d);
        if (clr) model_fill();
        if (we) mbuf[a] = d;
    endtask

    // Expected frame: row-0 address, row-0 text, row-1 address, row-1 text.
    task automatic build_frame();
        exp_q.delete();
        exp_q.push_back(9'h080);
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mbuf[c]});
        exp_q.push_back(9'h0C0);
        for (int c = 16; c < 32; c++) exp_q.push_back({1'b1, mbuf[c]});
`ifdef LCD_CURSOR_EN
        exp_q.push_back(9'(9'h080 + ((int'(CURSOR) >= 16) ? 9'h040 : 9'h000) + 9'(int'(CURSOR) % 16)));
`endif
    endtask

    task automatic compare_frame(input int base, input string tag);
        for (int k = 0; k < NITEMS; k++) begin
            if (base + k >= sq.size()) begin
                check($sformatf("%s_item%0d_missing", tag, k), 32'd0, 32'd1);
                break;
            end
            check($sformatf("%s_item%0d", tag, k), 32'(sq[base + k]), 32'(exp_q[k]));
        end
    endtask

    task automatic step();
        @(negedge clock); #1;
    endtask

    task automatic apply_op(input logic clr, input logic we, input logic [4:0] a, input logic [7:0] d);
        step();
        clear_req = clr; wr_en = we; wr_addr = a; wr_data = d;
        model_write(clr, we, a, d);
        step();
        clear_req = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 20000) begin step(); n++; end
        check({tag, "_frame_done_count"}, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_strobes(input int target, input string tag);
        int n = 0;
        while (sq.size() < target && n < 5000) begin step(); n++; end
        check({tag, "_strobe_reached"}, 32'(sq.size() >= target), 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        int low = 0;
        while (low < 8 && n < 5000) begin
            step(); n++;
            if (refreshing) low = 0; else low++;
        end
        check({tag, "_quiet"}, 32'(low >= 8), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d_in"}, 32'(lcd_d_in), 32'd0);
        check({tag, "_data_ready"}, 32'(lcd_data_ready), 32'd0);
        check({tag, "_refreshing"}, 32'(refreshing), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // ---------------- test sequence --------------------------------------
    initial begin
        vec_t tbl[6];
        int   base;
        int   d0;
        int   nf;
        tbl[0] = '{1'b0, 5'd17, 8'h35, 19, 9'h135};
        tbl[1] = '{1'b1, 5'd5,  8'h39, 6,  9'h139};
        tbl[2] = '{1'b0, 5'd31, 8'h7E, 33, 9'h17E};
        tbl[3] = '{1'b0, 5'd15, 8'h30, 16, 9'h130};
        tbl[4] = '{1'b0, 5'd16, 8'h31, 18, 9'h131};
        tbl[5] = '{1'b1, 5'd8,  8'h2A, 9,  9'h12A};

        internal_reset = 1'b1; wr_en = 1'b0; clear_req = 1'b0;
        wr_addr = 5'd0; wr_data = 8'h00; cursor_pos = CURSOR;
        model_fill();
        repeat (4) step();
        check_reset_outputs("reset");

        // Reset and init: no strobe until the driver's init busy falls.
        internal_reset = 1'b0;
        repeat (3) step();
        init_busy = 1'b1;
        repeat (100) step();
        check("no_strobe_during_init", 32'(sq.size()), 32'd0);
        check("no_refresh_during_init", 32'(refreshing), 32'd0);
        init_busy = 1'b0;
        wait_done(1, "init");
        wait_quiet("init");
        check("init_strobe_count", 32'(sq.size()), 32'(NITEMS));
        check("init_first_word", 32'(sq[0]), 32'h080);
        check("init_second_word", 32'(sq[1]), 32'h120);
        check("init_frame_done_once", 32'(done_cnt), 32'd1);
        build_frame();
        compare_frame(0, "init");

        // Table of single writes (optionally with a same-cycle clear).
        for (int t = 0; t < 6; t++) begin
            base = sq.size(); d0 = done_cnt;
            apply_op(tbl[t].clr, 1'b1, tbl[t].addr, tbl[t].data);
            wait_done(d0 + 1, $sformatf("tbl%0d", t));
            wait_quiet($sformatf("tbl%0d", t));
            check($sformatf("tbl%0d_count", t), 32'(sq.size() - base), 32'(NITEMS));
            check($sformatf("tbl%0d_word", t), 32'(sq[base + tbl[t].item]), 32'(tbl[t].exp_word));
            build_frame();
            compare_frame(base, $sformatf("tbl%0d", t));
        end

        // Write mid-refresh: a second full frame follows the first.
        base = sq.size(); d0 = done_cnt;
        apply_op(1'b0, 1'b1, 5'd2, 8'h42);
        build_frame(); saved_q = exp_q;
        wait_strobes(base + 11, "mid");
        apply_op(1'b0, 1'b1, 5'd0, 8'h41);
        wait_done(d0 + 2, "mid");
        wait_quiet("mid");
        check("mid_count", 32'(sq.size() - base), 32'(2 * NITEMS));
        exp_q = saved_q;
        compare_frame(base, "mid_f1");
        build_frame();
        compare_frame(base + NITEMS, "mid_f2");
        check("mid_f2_item1", 32'(sq[base + NITEMS + 1]), 32'h141);

        // Ack timeout: first strobe ignored, same item re-issued.
        base = sq.size(); d0 = done_cnt;
        ignore_req = 1'b1;
        apply_op(1'b0, 1'b1, 5'd3, 8'h43);
        wait_done(d0 + 1, "tmo");
        wait_quiet("tmo");
        ignore_req = 1'b0;
        check("tmo_count", 32'(sq.size() - base), 32'(NITEMS + 1));
        check("tmo_first", 32'(sq[base]), 32'h080);
        check("tmo_reissue", 32'(sq[base + 1]), 32'h080);
        check("tmo_gap", 32'(scyc[base + 1] - scyc[base]), 32'(ACK_TIMEOUT + 1));
        build_frame();
        compare_frame(base + 1, "tmo");

        // Reset mid-frame at item 20.
        base = sq.size(); d0 = done_cnt;
        apply_op(1'b0, 1'b1, 5'd20, 8'h44);
        wait_strobes(base + 21, "rst");
        internal_reset = 1'b1;
        model_fill();
        step();
        check_reset_outputs("midrst");
        repeat (2) step();
        internal_reset = 1'b0;
        check("midrst_no_frame_done", 32'(done_cnt), 32'(d0));
        repeat (3) step();
        init_busy = 1'b1;
        repeat (20) step();
        init_busy = 1'b0;
        base = sq.size();
        wait_done(d0 + 1, "rst");
        wait_quiet("rst");
        check("rst_count", 32'(sq.size() - base), 32'(NITEMS));
        build_frame();
        compare_frame(base, "rst");

        // Randomized write bursts against the model.
        for (int r = 0; r < 8; r++) begin
            int len;
            base = sq.size(); d0 = done_cnt;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                logic c;
                logic w;
                step();
                c = ($urandom_range(0, 7) == 0);
                w = ($urandom_range(0, 5) != 0) || !c;
                clear_req = c; wr_en = w;
                wr_addr = 5'($urandom_range(0, 31));
                wr_data = 8'($urandom_range(0, 255));
                model_write(c, w, wr_addr, wr_data);
            end
            step();
            clear_req = 1'b0; wr_en = 1'b0;
            wait_done(d0 + 1, $sformatf("rnd%0d", r));
            wait_quiet($sformatf("rnd%0d", r));
            nf = done_cnt - d0;
            check($sformatf("rnd%0d_frames", r), 32'(nf >= 1 && nf <= 2), 32'd1);
            check($sformatf("rnd%0d_count", r), 32'(sq.size() - base), 32'(nf * NITEMS));
            build_frame();
            for (int f = 0; f < nf; f++) compare_frame(base + f * NITEMS, $sformatf("rnd%0d_f%0d", r, f));
        end

        check("strobe_single_cycle", 32'(viol_pulse), 32'd0);
        check("frame_done_with_refresh_fall", 32'(viol_done), 32'd0);
        check("d_in_held_while_busy", 32'(viol_hold), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
